// File: rtl/noc_input_buffer_if.sv
// Handshake and status bundle between a router port's input buffer and the crossbar.
// The crossbar side is the master: it pushes flits in and pops them out.
// The buffer side is the slave: it reports the front flit and status.
interface noc_input_buffer_if #(
    parameter int addr_w = 3,
    parameter int width  = 10
);
    logic [width-1:0]  in;
    logic              push;
    logic              pop;
    logic [width-1:0]  out;
    logic [addr_w-1:0] empty_room;
    logic [addr_w-1:0] packet_size;
    // Destination id of the front packet ("dist" is a reserved word in SystemVerilog).
    logic [width-3:0]  dist_id;
    logic              overflow;
    logic              underflow;

    modport master (
        output in, push, pop,
        input  out, empty_room, packet_size, dist_id, overflow, underflow
    );

    modport slave (
        input  in, push, pop,
        output out, empty_room, packet_size, dist_id, overflow, underflow
    );
endinterface

// File: rtl/noc_input_buffer.sv
// Store-and-forward input buffer for one mesh-router port.
// Flits sit in a circular store with first-word fall-through.
// A side FIFO of packet lengths holds one entry per packet whose tail has arrived.
// A packet's size becomes visible to the crossbar only once that packet is complete.
module noc_input_buffer #(
    parameter int addr_w = 3,
    parameter int width  = 10
) (
    input  logic              clk,
    input  logic              rst,
    noc_input_buffer_if.slave bus
);

    localparam int SLOTS = 1 << addr_w;
    localparam int DEPTH = SLOTS - 1;
    localparam logic [addr_w-1:0] DEPTH_V = addr_w'(DEPTH);
    localparam logic [addr_w-1:0] ONE     = addr_w'(1);

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_TAIL   = 2'b01,
        FT_HEAD   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    logic [width-1:0]  mem [SLOTS];
    logic [addr_w-1:0] wr_ptr;
    logic [addr_w-1:0] rd_ptr;
    logic [addr_w-1:0] cnt;

    logic [addr_w-1:0] len_mem [SLOTS];
    logic [addr_w-1:0] len_wr;
    logic [addr_w-1:0] len_rd;
    logic [addr_w-1:0] len_cnt;

    logic [addr_w-1:0] acc;
    logic [addr_w-1:0] popped;
    logic [width-3:0]  dist_q;
    logic              overflow_q;
    logic              underflow_q;

    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;
    logic              len_empty;
    logic              len_push;
    logic              len_pop;
    logic [width-1:0]  front;
    flit_type_e        in_type;
    flit_type_e        front_type;
    logic              in_ends_packet;
    logic              front_ends_packet;

    // Full is judged on the occupancy before this edge's pop, so a pop cannot make room for a simultaneous push.
    assign full      = (cnt == DEPTH_V);
    assign empty     = (cnt == '0);
    assign push_ok   = bus.push && !full;
    assign pop_ok    = bus.pop && !empty;
    assign len_empty = (len_cnt == '0);

    assign front             = empty ? '0 : mem[rd_ptr];
    assign in_type           = flit_type_e'(bus.in[width-1:width-2]);
    assign front_type        = flit_type_e'(front[width-1:width-2]);
    assign in_ends_packet    = (in_type == FT_TAIL) || (in_type == FT_SINGLE);
    assign front_ends_packet = (front_type == FT_TAIL) || (front_type == FT_SINGLE);

    // A length entry is written only when a packet is closed and removed when its last flit leaves.
    assign len_push = push_ok && in_ends_packet;
    assign len_pop  = pop_ok && front_ends_packet && !len_empty;

    // Flit storage write port; the contents need no reset because cnt gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.in;
        end
    end

    // Main store pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ONE;
            end
            if (push_ok && !pop_ok) begin
                cnt <= cnt + ONE;
            end else if (pop_ok && !push_ok) begin
                cnt <= cnt - ONE;
            end
        end
    end

    // Length FIFO storage; an entry is acc+1, the full length of the packet just closed.
    always_ff @(posedge clk) begin
        if (len_push) begin
            len_mem[len_wr] <= acc + ONE;
        end
    end

    // Length FIFO pointers and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_wr  <= '0;
            len_rd  <= '0;
            len_cnt <= '0;
        end else begin
            if (len_push) begin
                len_wr <= len_wr + ONE;
            end
            if (len_pop) begin
                len_rd <= len_rd + ONE;
            end
            if (len_push && !len_pop) begin
                len_cnt <= len_cnt + ONE;
            end else if (len_pop && !len_push) begin
                len_cnt <= len_cnt - ONE;
            end
        end
    end

    // Per-packet counters: flits accepted into the open packet and flits already drained from the front packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            popped <= '0;
        end else begin
            if (push_ok) begin
                if (in_ends_packet) begin
                    acc <= '0;
                end else begin
                    acc <= acc + ONE;
                end
            end
            if (pop_ok) begin
                if (front_ends_packet) begin
                    popped <= '0;
                end else begin
                    popped <= popped + ONE;
                end
            end
        end
    end

    // Remember the destination once the head leaves, so body and tail flits still report it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dist_q <= '0;
        end else if (pop_ok && (front_type == FT_HEAD)) begin
            dist_q <= front[width-3:0];
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.push && full) begin
                overflow_q <= 1'b1;
            end
            if (bus.pop && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.out         = front;
    assign bus.empty_room  = DEPTH_V - cnt;
    assign bus.packet_size = len_empty ? '0 : (len_mem[len_rd] - popped);
    assign bus.dist_id     = ((front_type == FT_HEAD) || (front_type == FT_SINGLE))
                             ? front[width-3:0] : dist_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_noc_input_buffer.sv
// Self-checking bench for noc_input_buffer (addr_w=3, width=10, capacity 7).
// A queue-based reference model tracks flits and complete-packet lengths.
module tb_noc_input_buffer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    noc_input_buffer_if #(.addr_w(3), .width(10)) bus();

    noc_input_buffer #(.addr_w(3), .width(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       push;
        logic       pop;
        logic [9:0] din;
        logic [9:0] e_out;
        logic [2:0] e_room;
        logic [2:0] e_psize;
        logic [7:0] e_dist;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    vec_t vecs [9];

    // Reference model: flit queue, queue of completed packet lengths, packet counters, flags.
    logic [9:0] mq [$];
    int         mlen [$];
    int         m_acc;
    int         m_popped;
    logic [7:0] m_dq;
    logic       m_ovf;
    logic       m_unf;
    int         gen_left;

    function automatic void modelReset();
        mq.delete();
        mlen.delete();
        m_acc    = 0;
        m_popped = 0;
        m_dq     = 8'h00;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endfunction

    function automatic void modelStep(logic p, logic q, logic [9:0] d);
        bit was_full  = (mq.size() == 7);
        bit was_empty = (mq.size() == 0);
        logic [9:0] f;
        if (p && was_full) m_ovf = 1'b1;
        if (q && was_empty) m_unf = 1'b1;
        if (q && !was_empty) begin
            f = mq.pop_front();
            m_popped++;
            if (f[9:8] == 2'b10) m_dq = f[7:0];
            if (f[8]) begin
                if (mlen.size() > 0) void'(mlen.pop_front());
                m_popped = 0;
            end
        end
        if (p && !was_full) begin
            mq.push_back(d);
            if (d[8]) begin
                mlen.push_back((m_acc + 1) % 8);
                m_acc = 0;
            end else begin
                m_acc++;
            end
        end
    endfunction

    function automatic logic [9:0] expOut();
        return (mq.size() == 0) ? 10'h000 : mq[0];
    endfunction

    function automatic logic [2:0] expRoom();
        return 3'(7 - mq.size());
    endfunction

    function automatic logic [2:0] expPsize();
        if (mlen.size() == 0) return 3'd0;
        return 3'((mlen[0] - m_popped) & 7);
    endfunction

    function automatic logic [7:0] expDist();
        logic [9:0] o = expOut();
        return o[9] ? o[7:0] : m_dq;
    endfunction

    // Well-formed packet generator: lengths 1..4, random payloads.
    function automatic logic [9:0] nextFlit();
        int len;
        logic [7:0] pl = 8'($urandom);
        if (gen_left == 0) begin
            len = $urandom_range(1, 4);
            if (len == 1) return {2'b11, pl};
            gen_left = len - 1;
            return {2'b10, pl};
        end
        gen_left--;
        return (gen_left == 0) ? {2'b01, pl} : {2'b00, pl};
    endfunction

    task automatic compare(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic checkOutput(string nm, logic [9:0] e_out, logic [2:0] e_room,
                               logic [2:0] e_psize, logic [7:0] e_dist,
                               logic e_ovf, logic e_unf);
        compare({nm, ".out"},         32'(bus.out),         32'(e_out));
        compare({nm, ".empty_room"},  32'(bus.empty_room),  32'(e_room));
        compare({nm, ".packet_size"}, 32'(bus.packet_size), 32'(e_psize));
        compare({nm, ".dist"},        32'(bus.dist_id),     32'(e_dist));
        compare({nm, ".overflow"},    32'(bus.overflow),    32'(e_ovf));
        compare({nm, ".underflow"},   32'(bus.underflow),   32'(e_unf));
    endtask

    task automatic checkModel(string nm);
        checkOutput(nm, expOut(), expRoom(), expPsize(), expDist(), m_ovf, m_unf);
    endtask

    // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
    task automatic applyStimulus(logic p, logic q, logic [9:0] d);
        bus.push = p;
        bus.pop  = q;
        bus.in   = d;
        @(posedge clk);
        modelStep(p, q, d);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulseReset(string nm);
        #2 rst = 1'b1;
        #1 checkOutput({nm, ".during"}, 10'h000, 3'd7, 3'd0, 8'h00, 1'b0, 1'b0);
        #2 rst = 1'b0;
        modelReset();
        #1 checkOutput({nm, ".after"}, 10'h000, 3'd7, 3'd0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 10'h305, 10'h305, 3'd6, 3'd1, 8'h05, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 10'h000, 10'h000, 3'd7, 3'd0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 10'h203, 10'h203, 3'd6, 3'd0, 8'h03, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 10'h00A, 10'h203, 3'd5, 3'd0, 8'h03, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 10'h107, 10'h203, 3'd4, 3'd3, 8'h03, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 10'h000, 10'h00A, 3'd5, 3'd2, 8'h03, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 10'h000, 10'h107, 3'd6, 3'd1, 8'h03, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 10'h000, 10'h000, 3'd7, 3'd0, 8'h03, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 10'h000, 10'h000, 3'd7, 3'd0, 8'h03, 1'b0, 1'b1};

        rst      = 1'b1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.in   = 10'h000;
        gen_left = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 10'h000, 3'd7, 3'd0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // Load a flit and make a pop on empty, then reset asynchronously mid-cycle.
        applyStimulus(1'b0, 1'b1, 10'h000);
        applyStimulus(1'b1, 1'b0, 10'h305);
        checkOutput("pre_reset", 10'h305, 3'd6, 3'd1, 8'h05, 1'b0, 1'b1);
        pulseReset("async_reset");

        // Single flit, three-flit packet, pop on empty.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].din);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_room,
                        vecs[i].e_psize, vecs[i].e_dist, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Full buffer: drop on full, push+pop while full keeps the push dropped.
        pulseReset("before_full");
        for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 1'b0, {2'b11, 8'(i)});
        checkOutput("full.fill", 10'h301, 3'd0, 3'd1, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 10'h308);
        checkOutput("full.drop", 10'h301, 3'd0, 3'd1, 8'h01, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 10'h309);
        checkOutput("full.pushpop", 10'h302, 3'd1, 3'd1, 8'h02, 1'b1, 1'b0);
        for (int k = 3; k <= 7; k++) begin
            applyStimulus(1'b0, 1'b1, 10'h000);
            compare($sformatf("full.drain%0d", k), 32'(bus.out), 32'({2'b11, 8'(k)}));
        end
        applyStimulus(1'b0, 1'b1, 10'h000);
        checkOutput("full.empty", 10'h000, 3'd7, 3'd0, 8'h00, 1'b1, 1'b0);

        // Stream of singles with a one-cycle lag wraps the pointers repeatedly.
        pulseReset("before_wrap");
        for (int i = 0; i <= 20; i++) begin
            applyStimulus(i < 20, i > 0, {2'b11, 8'(i + 16)});
            if (i < 20) begin
                compare($sformatf("wrap%0d.out", i), 32'(bus.out), 32'({2'b11, 8'(i + 16)}));
                compare($sformatf("wrap%0d.room", i), 32'(bus.empty_room), 32'd6);
            end else begin
                checkOutput("wrap.end", 10'h000, 3'd7, 3'd0, 8'h00, 1'b0, 1'b0);
            end
        end

        // Reset in the middle of a packet discards partial counts.
        pulseReset("before_midpkt");
        applyStimulus(1'b1, 1'b0, 10'h209);
        applyStimulus(1'b1, 1'b0, 10'h001);
        pulseReset("midpkt");
        applyStimulus(1'b1, 1'b0, 10'h30C);
        checkOutput("midpkt.single", 10'h30C, 3'd6, 3'd1, 8'h0C, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 10'h000);
        checkOutput("midpkt.drain", 10'h000, 3'd7, 3'd0, 8'h00, 1'b0, 1'b0);

        // Randomized traffic against the reference model: fill-heavy, then drain-heavy.
        pulseReset("before_rand");
        gen_left = 0;
        for (int c = 0; c < 600; c++) begin
            logic p;
            logic q;
            logic [9:0] d;
            p = (c < 300) ? ($urandom_range(0, 99) < 65) : ($urandom_range(0, 99) < 35);
            q = (c < 300) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 65);
            d = (p && mq.size() < 7) ? nextFlit() : 10'($urandom);
            applyStimulus(p, q, d);
            checkModel($sformatf("rand%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
